// File: rtl/icache_data_refill_if.sv
// AXI4 read-address / read-data channel used by the I$ data stage to refill lines.
interface icache_data_refill_if;
  logic        arvalid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rready;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/icache_data_refill.sv
// N-way I$ data stage: tag compare, one-cycle hit delivery to ID, and AXI4 line refill
// that can be aborted by flush without disturbing the array or the AXI handshake.
module icache_data_refill #(
  parameter int NUM_WAYS   = 4,
  parameter int NUM_SETS   = 64,
  parameter int LINE_BYTES = 32,
  localparam int OFF_W = $clog2(LINE_BYTES),
  localparam int SET_W = $clog2(NUM_SETS),
  localparam int TAG_W = 32 - SET_W - OFF_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      req_valid,
  input  logic [31:0]               req_pc,
  input  logic [NUM_WAYS-1:0]       tag_valid,
  input  logic [NUM_WAYS*TAG_W-1:0] tags_read,
  output logic                      icache_busy,
  output logic                      instr_valid,
  output logic [31:0]               instr,
  output logic [31:0]               instr_pc,
  output logic [NUM_WAYS-1:0]       upd_tag_en,
  output logic [SET_W-1:0]          upd_set,
  output logic [TAG_W-1:0]          upd_tag,
  icache_data_refill_if.master      axi
);

  localparam int WORDS = LINE_BYTES / 4;
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int WRD_W = OFF_W - 2;
  localparam logic [NUM_WAYS-1:0] ONE_WAY = {{(NUM_WAYS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_FETCH = 3'd2,
    ST_FILL  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t             state_r;
  logic               arvalid_r;
  logic [31:0]        araddr_r;
  logic [WAY_W-1:0]   victim_r;
  logic               victim_rr_r;
  logic [WAY_W-1:0]   rr_ptr_r;
  logic [WRD_W-1:0]   beat_r;
  logic               abort_r;

  logic [31:0] line_buf_r [WORDS];
  logic [31:0] data_mem   [NUM_WAYS][NUM_SETS][WORDS];

  logic [TAG_W-1:0]    req_tag_s;
  logic [SET_W-1:0]    req_set_s;
  logic [WRD_W-1:0]    req_word_s;
  logic                q_s;
  logic [NUM_WAYS-1:0] hit_vec_s;
  logic [WAY_W-1:0]    hit_way_s;
  logic                inv_found_s;
  logic [WAY_W-1:0]    inv_way_s;
  logic                hit_s;
  logic                miss_s;
  logic                unused_s;

  assign req_tag_s  = req_pc[31 -: TAG_W];
  assign req_set_s  = req_pc[OFF_W +: SET_W];
  assign req_word_s = req_pc[OFF_W-1:2];
  assign unused_s   = ^req_pc[1:0];
  assign q_s        = req_valid & ~stall & ~flush;
  assign hit_s      = q_s & (|hit_vec_s);
  assign miss_s     = q_s & ~(|hit_vec_s) & (state_r == ST_IDLE);

  assign axi.arvalid = arvalid_r;
  assign axi.araddr  = araddr_r;
  assign axi.arlen   = 8'(WORDS - 1);
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.rready  = 1'b1;

  // Way match plus lowest-index hit and lowest-index invalid way (descending scan, last write wins).
  always_comb begin
    hit_vec_s   = {NUM_WAYS{1'b0}};
    hit_way_s   = {WAY_W{1'b0}};
    inv_found_s = 1'b0;
    inv_way_s   = {WAY_W{1'b0}};
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      hit_vec_s[i] = tag_valid[i] && (tags_read[i*TAG_W +: TAG_W] == req_tag_s);
      hit_way_s    = hit_vec_s[i] ? WAY_W'(i) : hit_way_s;
      inv_way_s    = tag_valid[i] ? inv_way_s : WAY_W'(i);
      inv_found_s  = inv_found_s | ~tag_valid[i];
    end
  end

  // Refill controller: AR issue, beat collection, array fill, and flush-abort draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      icache_busy <= 1'b0;
      arvalid_r   <= 1'b0;
      araddr_r    <= 32'h0000_0000;
      upd_tag_en  <= {NUM_WAYS{1'b0}};
      upd_set     <= {SET_W{1'b0}};
      upd_tag     <= {TAG_W{1'b0}};
      victim_r    <= {WAY_W{1'b0}};
      victim_rr_r <= 1'b0;
      rr_ptr_r    <= {WAY_W{1'b0}};
      beat_r      <= {WRD_W{1'b0}};
      abort_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (miss_s) begin
            araddr_r    <= {req_pc[31:OFF_W], {OFF_W{1'b0}}};
            upd_set     <= req_set_s;
            upd_tag     <= req_tag_s;
            victim_r    <= inv_found_s ? inv_way_s : rr_ptr_r;
            victim_rr_r <= ~inv_found_s;
            abort_r     <= 1'b0;
            icache_busy <= 1'b1;
            arvalid_r   <= 1'b1;
            state_r     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // arvalid must stay up until the handshake; a flush here only arms the abort.
          if (axi.arready) begin
            arvalid_r <= 1'b0;
            beat_r    <= {WRD_W{1'b0}};
            state_r   <= (abort_r | flush) ? ST_DRAIN : ST_FETCH;
          end else if (flush) begin
            abort_r <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (flush) begin
            if (axi.rvalid && axi.rlast) begin
              state_r     <= ST_IDLE;
              icache_busy <= 1'b0;
            end else begin
              state_r <= ST_DRAIN;
            end
          end else if (axi.rvalid) begin
            beat_r <= beat_r + WRD_W'(1);
            if (axi.rlast) begin
              upd_tag_en <= ONE_WAY << victim_r;
              state_r    <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          upd_tag_en  <= {NUM_WAYS{1'b0}};
          rr_ptr_r    <= victim_rr_r ? rr_ptr_r + WAY_W'(1) : rr_ptr_r;
          icache_busy <= 1'b0;
          state_r     <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (axi.rvalid && axi.rlast) begin
            icache_busy <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          icache_busy <= 1'b0;
          arvalid_r   <= 1'b0;
          upd_tag_en  <= {NUM_WAYS{1'b0}};
        end
      endcase
    end
  end

  // ID valid: flush kills, stall holds, otherwise follows this cycle's hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end else if (!stall) begin
      instr_valid <= hit_s;
    end
  end

  // Unreset storage: line buffer capture, whole-line array write, ID data/PC capture.
  always_ff @(posedge clk) begin
    if (state_r == ST_FETCH && axi.rvalid && !flush) begin
      line_buf_r[beat_r] <= axi.rdata;
    end
    if (state_r == ST_FILL) begin
      for (int w = 0; w < WORDS; w++) begin
        data_mem[victim_r][upd_set][w] <= line_buf_r[w];
      end
    end
    if (hit_s) begin
      instr    <= data_mem[hit_way_s][req_set_s][req_word_s];
      instr_pc <= req_pc;
    end
  end

endmodule

// File: tb/tb_icache_data_refill.sv
// Directed bench for icache_data_refill (4 ways, 64 sets, 32-byte lines) with a tag-store model.
module tb_icache_data_refill;
  localparam int TAG_W = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_pc;
  logic [3:0]  tag_valid;
  logic [4*TAG_W-1:0] tags_read;
  logic        icache_busy;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [3:0]  upd_tag_en;
  logic [5:0]  upd_set;
  logic [TAG_W-1:0] upd_tag;

  icache_data_refill_if axi_bus ();

  icache_data_refill dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .tag_valid   (tag_valid),
    .tags_read   (tags_read),
    .icache_busy (icache_busy),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .upd_tag_en  (upd_tag_en),
    .upd_set     (upd_set),
    .upd_tag     (upd_tag),
    .axi         (axi_bus)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int upd_cnt = 0;

  // Tag store as the IFT stage would hold it, written by the DUT's update strobe.
  bit             tag_v_m [64][4];
  bit [TAG_W-1:0] tag_m   [64][4];

  always_comb begin
    tag_valid = 4'b0000;
    tags_read = '0;
    for (int w = 0; w < 4; w++) begin
      tag_valid[w]               = tag_v_m[req_pc[10:5]][w];
      tags_read[w*TAG_W +: TAG_W] = tag_m[req_pc[10:5]][w];
    end
  end

  always @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      if (upd_tag_en[w]) begin
        tag_v_m[upd_set][w] <= 1'b1;
        tag_m[upd_set][w]   <= upd_tag;
      end
    end
    if (|upd_tag_en) upd_cnt <= upd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Miss on pc, serve one 8-beat burst whose beat k is d0+k; optional flush in ISSUE or on a beat.
  task automatic refill(input logic [31:0] pc, input logic [31:0] d0, input int ar_delay,
                        input bit flush_issue, input int flush_beat, input logic [3:0] exp_upd);
    int upd0;
    bit aborted;
    aborted = flush_issue || (flush_beat >= 0);
    upd0 = upd_cnt;
    req_valid = 1'b1;
    req_pc    = pc;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_on_miss", 32'(icache_busy), 32'd1);
    chk("arvalid", 32'(axi_bus.arvalid), 32'd1);
    chk("araddr", axi_bus.araddr, pc & 32'hFFFF_FFE0);
    chk("arlen", 32'(axi_bus.arlen), 32'd7);
    for (int i = 0; i < ar_delay; i++) begin
      flush = flush_issue && (i == 0);
      @(negedge clk);
      flush = 1'b0;
      chk("arvalid_hold", 32'(axi_bus.arvalid), 32'd1);
    end
    axi_bus.arready = 1'b1;
    @(negedge clk);
    axi_bus.arready = 1'b0;
    chk("arvalid_drop", 32'(axi_bus.arvalid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      axi_bus.rvalid = 1'b1;
      axi_bus.rdata  = d0 + 32'(k);
      axi_bus.rlast  = (k == 7);
      flush          = (k == flush_beat);
      @(negedge clk);
      flush = 1'b0;
      if (k < 7) chk("busy_in_burst", 32'(icache_busy), 32'd1);
    end
    axi_bus.rvalid = 1'b0;
    axi_bus.rlast  = 1'b0;
    if (aborted) begin
      chk("busy_after_drain", 32'(icache_busy), 32'd0);
      chk("no_upd_in_drain", 32'(upd_tag_en), 32'd0);
    end else begin
      chk("upd_tag_en", 32'(upd_tag_en), 32'(exp_upd));
      chk("busy_in_fill", 32'(icache_busy), 32'd1);
      chk("upd_tag", 32'(upd_tag), 32'(pc[31:11]));
      @(negedge clk);
      chk("upd_clear", 32'(upd_tag_en), 32'd0);
      chk("busy_idle", 32'(icache_busy), 32'd0);
    end
    chk("upd_pulses", 32'(upd_cnt - upd0), aborted ? 32'd0 : 32'd1);
  endtask

  task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] exp);
    req_valid = 1'b1;
    req_pc    = pc;
    @(negedge clk);
    req_valid = 1'b0;
    chk("hit_valid", 32'(instr_valid), 32'd1);
    chk("hit_instr", instr, exp);
    chk("hit_pc", instr_pc, pc);
    chk("hit_not_busy", 32'(icache_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    req_valid = 1'b0;
    req_pc = 32'h0000_0000;
    axi_bus.arready = 1'b0;
    axi_bus.rvalid  = 1'b0;
    axi_bus.rdata   = 32'h0000_0000;
    axi_bus.rlast   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(icache_busy), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_upd", 32'(upd_tag_en), 32'd0);
    chk("rst_arvalid", 32'(axi_bus.arvalid), 32'd0);
    chk("rready", 32'(axi_bus.rready), 32'd1);
    chk("arsize", 32'(axi_bus.arsize), 32'd2);
    chk("arburst", 32'(axi_bus.arburst), 32'd1);

    // Cold miss and offset select on line 0x100 (words 0xA0..0xA7).
    refill(32'h0000_0100, 32'h0000_00A0, 0, 1'b0, -1, 4'b0001);
    fetch_hit(32'h0000_0100, 32'h0000_00A0);
    fetch_hit(32'h0000_011C, 32'h0000_00A7);
    fetch_hit(32'h0000_0104, 32'h0000_00A1);

    // Stall holds ID, flush clears it, miss+flush starts nothing.
    stall = 1'b1; req_valid = 1'b1; req_pc = 32'h0000_011C;
    @(negedge clk);
    chk("stall_hold_valid", 32'(instr_valid), 32'd1);
    chk("stall_hold_instr", instr, 32'h0000_00A1);
    stall = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_kill", 32'(instr_valid), 32'd0);
    req_pc = 32'h0000_7000;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("miss_flush_busy", 32'(icache_busy), 32'd0);
    chk("miss_flush_ar", 32'(axi_bus.arvalid), 32'd0);

    // Replacement in set 0: invalid ways first, then round robin.
    refill(32'h0000_0800, 32'h1000_0010, 0, 1'b0, -1, 4'b0001);
    refill(32'h0000_1000, 32'h1000_0020, 1, 1'b0, -1, 4'b0010);
    refill(32'h0000_1800, 32'h1000_0030, 0, 1'b0, -1, 4'b0100);
    refill(32'h0000_2000, 32'h1000_0040, 2, 1'b0, -1, 4'b1000);
    refill(32'h0000_2800, 32'h1000_0050, 0, 1'b0, -1, 4'b0001);
    refill(32'h0000_3000, 32'h1000_0060, 0, 1'b0, -1, 4'b0010);
    fetch_hit(32'h0000_2800, 32'h1000_0050);
    fetch_hit(32'h0000_3004, 32'h1000_0061);
    fetch_hit(32'h0000_1808, 32'h1000_0032);
    fetch_hit(32'h0000_201C, 32'h1000_0047);

    // Flush on beat 3: drain, no tag update, same PC misses again.
    refill(32'h0000_4060, 32'hB000_0000, 0, 1'b0, 3, 4'b0000);
    refill(32'h0000_4060, 32'hB100_0000, 0, 1'b0, -1, 4'b0001);
    fetch_hit(32'h0000_4064, 32'hB100_0001);

    // Flush while AR is waiting 3 cycles for arready.
    refill(32'h0000_50A0, 32'hD000_0000, 3, 1'b1, -1, 4'b0000);

    // Async reset between edges in FETCH.
    req_valid = 1'b1; req_pc = 32'h0000_3040;
    @(negedge clk);
    req_valid = 1'b0; axi_bus.arready = 1'b1;
    @(negedge clk);
    axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'hEEEE_0000;
    repeat (2) @(negedge clk);
    axi_bus.rvalid = 1'b0;
    chk("pre_rst_busy", 32'(icache_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(icache_busy), 32'd0);
    chk("async_rst_arvalid", 32'(axi_bus.arvalid), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    refill(32'h0000_3040, 32'h0000_00C0, 0, 1'b0, -1, 4'b0001);
    fetch_hit(32'h0000_3048, 32'h0000_00C2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
